alu_exec_unit: RTL
==================

ALU_EXEC_UNIT -- requirements
Module: alu_exec_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width.
REQ-002 SHALL have parameter SHW, default 5, shift-amount width (log2 XLEN).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port in_valid  input  1  operation request present.
REQ-006 SHALL have port in_ready  output  1  unit can accept a request.
REQ-007 SHALL have port alucon  input  4  ALU operation code, as produced by the ALU control decoder.
REQ-008 SHALL have port a  input  XLEN  operand A.
REQ-009 SHALL have port b  input  XLEN  operand B; b[SHW-1:0] is the shift amount for shifts.
REQ-010 SHALL have port out_valid  output  1  result available.
REQ-011 SHALL have port out_ready  input  1  consumer accepts result.
REQ-012 SHALL have port result  output  XLEN  operation result.
REQ-013 SHALL have port zero  output  1  result == 0.
REQ-014 SHALL have port illegal  output  1  accepted alucon was not a defined code.

Function
REQ-015 Codes SHALL be: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0011 XOR, 0100 SLL, 0101 SRL; all others illegal.
REQ-016 Request SHALL be accepted in a cycle where in_valid && in_ready; alucon, a, b captured at that edge.
REQ-017 States SHALL be IDLE, SHIFT, DONE; in_ready = 1 only in IDLE.
REQ-018 IDLE: on accept of AND/OR/ADD/SUB/XOR or illegal code -> DONE with result registered; out_valid asserted the next cycle (latency 1).
REQ-019 IDLE: on accept of SLL/SRL with shamt != 0 -> SHIFT, shift register loaded with a, counter loaded with shamt.
REQ-020 IDLE: on accept of SLL/SRL with shamt == 0 -> DONE, result = a (latency 1).
REQ-021 SHIFT: shift register moves one bit per cycle (SLL left, SRL right, zero fill); counter decrements; at counter reaching 0 -> DONE; total latency 1 + shamt cycles.
REQ-022 ADD/SUB SHALL be modulo 2^XLEN, carry/borrow discarded.
REQ-023 Illegal code: result = 0, zero = 1, illegal = 1; otherwise illegal = 0.
REQ-024 DONE: out_valid = 1; result, zero, illegal held stable until out_valid && out_ready; then -> IDLE.
REQ-025 In DONE, in_valid SHALL be ignored; no accept until IDLE (no back-to-back overlap; max throughput one op per 2 cycles).
REQ-026 in_valid while not in IDLE SHALL not alter captured operands.
REQ-027 zero SHALL be derived from the registered result, valid only while out_valid = 1.

Reset
REQ-028 rst SHALL override all other inputs at the clock edge, including mid-SHIFT and in DONE awaiting out_ready.
REQ-029 After reset: state IDLE, in_ready = 1, out_valid = 0, result = 0, zero = 1, illegal = 0, counter = 0.
REQ-030 An operation in flight at reset SHALL be discarded with no out_valid pulse.

Structure
REQ-031 Package alu_pkg SHALL hold the alucon code constants and the state enumeration; shared with the ALU control decoder.
REQ-032 Single-cycle ops SHALL be in one combinational sub-module alu_comb (alucon, a, b -> value, illegal); FSM, shifter, counter in alu_exec_unit.

Verification
REQ-033 ADD a=5, b=3, out_ready=1 -> out_valid one cycle after accept, result=8, zero=0.
REQ-034 SUB a=0x1234, b=0x1234 -> result=0, zero=1; SUB a=0, b=1 -> result=0xFFFFFFFF.
REQ-035 SLL a=1, b=4 -> out_valid exactly 5 cycles after accept, result=0x10; SRL a=0x80000000, b=31 -> 32 cycles, result=1; SLL b=0 -> 1 cycle, result=a.
REQ-036 ADD accepted, out_ready held 0 for 3 cycles -> out_valid, result stable 3 cycles, in_ready=0 throughout; in_ready=1 cycle after handshake.
REQ-037 SRL shamt=20, rst pulsed in 5th SHIFT cycle -> next cycle IDLE, out_valid=0, result=0; no result ever presented.
REQ-038 alucon=1111 -> result=0, zero=1, illegal=1; following legal op clears illegal.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: alucon code constants and exec-unit state enumeration shared with the ALU control decoder
package alu_pkg;
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_XOR = 4'b0011;
  localparam logic [3:0] ALU_SLL = 4'b0100;
  localparam logic [3:0] ALU_SRL = 4'b0101;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_DONE} state_e;
endpackage

// File: rtl/alu_comb.sv
// alu_comb: single-cycle ops (alucon, a, b -> value, illegal); shift codes are legal but yield 0 here
module alu_comb import alu_pkg::*; #(
  parameter int XLEN = 32
) (
  input  logic [3:0]      alucon,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic [XLEN-1:0] value,
  output logic            illegal
);
  always_comb begin
    value = '0;
    illegal = 1'b0;
    case (alucon)
      ALU_AND: value = a & b;
      ALU_OR:  value = a | b;
      ALU_ADD: value = a + b;
      ALU_SUB: value = a - b;
      ALU_XOR: value = a ^ b;
      ALU_SLL, ALU_SRL: value = '0;
      default: illegal = 1'b1;
    endcase
  end
endmodule

// File: rtl/alu_exec_unit.sv
// alu_exec_unit: valid/ready ALU (in_valid/in_ready, alucon/a/b in; out_valid/out_ready, result/zero/illegal out) with bit-serial shifts
module alu_exec_unit import alu_pkg::*; #(
  parameter int XLEN = 32,
  parameter int SHW  = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      alucon,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            illegal
);
  state_e          state_q, state_d;
  logic [XLEN-1:0] res_q, res_d;
  logic [SHW-1:0]  cnt_q, cnt_d;
  logic            sll_q, sll_d;
  logic            illegal_q, illegal_d;
  logic [XLEN-1:0] comb_val;
  logic            comb_ill;
  logic [SHW-1:0]  shamt;
  logic            is_shift;
  assign shamt = b[SHW-1:0];
  assign is_shift = alucon == ALU_SLL || alucon == ALU_SRL;
  alu_comb #(.XLEN(XLEN)) u_comb (
    .alucon (alucon),
    .a      (a),
    .b      (b),
    .value  (comb_val),
    .illegal(comb_ill)
  );
  assign in_ready = state_q == ST_IDLE;
  assign out_valid = state_q == ST_DONE;
  assign result = res_q;
  assign zero = res_q == '0;
  assign illegal = illegal_q;
  // res_q doubles as the shift register while in SHIFT
  always_comb begin
    state_d = state_q;
    res_d = res_q;
    cnt_d = cnt_q;
    sll_d = sll_q;
    illegal_d = illegal_q;
    case (state_q)
      ST_IDLE: if (in_valid) begin
        illegal_d = comb_ill;
        sll_d = alucon == ALU_SLL;
        cnt_d = is_shift ? shamt : '0;
        res_d = is_shift ? a : comb_val;
        state_d = is_shift && shamt != '0 ? ST_SHIFT : ST_DONE;
      end
      ST_SHIFT: begin
        res_d = sll_q ? res_q << 1 : res_q >> 1;
        cnt_d = cnt_q - 1'b1;
        state_d = cnt_d == '0 ? ST_DONE : ST_SHIFT;
      end
      ST_DONE: state_d = out_ready ? ST_IDLE : ST_DONE;
      default: state_d = ST_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      res_q <= '0;
      cnt_q <= '0;
      sll_q <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q <= state_d;
      res_q <= res_d;
      cnt_q <= cnt_d;
      sll_q <= sll_d;
      illegal_q <= illegal_d;
    end
  end
endmodule
